ahb_lite_mem_slave: RTL

- Parametrised AHB-Lite memory slave.
- Generalises the current fixed 32-bit, zero-wait slave: configurable data width, depth and wait states, byte-lane writes per HSIZE, and a two-cycle ERROR response for illegal accesses.
- Sits on the AHB-Lite bus behind the decoder, driven by the existing master task model.

---
 rtl/ahb_lite_mem_slave_pkg.sv | 44 ++++
 rtl/ahb_lite_mem_array.sv | 31 +++
 rtl/ahb_lite_mem_slave.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_mem_slave_pkg.sv
// Shared AHB-Lite codes, slave FSM encoding
// and the byte-lane mask helper.
package ahb_lite_mem_slave_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HS_BYTE  = 3'd0,
    HS_HALF  = 3'd1,
    HS_WORD  = 3'd2,
    HS_DWORD = 3'd3
  } hsize_e;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  function automatic logic [7:0] lane_mask(
    input logic [2:0] size,
    input logic [2:0] lo
  );
    logic [7:0] m;
    m = 8'hFF;
    unique case (size)
      HS_BYTE: m = 8'h01;
      HS_HALF: m = 8'h03;
      HS_WORD: m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << lo;
  endfunction

endpackage

// File: rtl/ahb_lite_mem_array.sv
// Byte-enable RAM: synchronous write,
// asynchronous read.
module ahb_lite_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int BW = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [BW-1:0]         i_be,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < BW; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// Parametrised AHB-Lite memory slave with
// wait states, byte lanes and ERROR response.
module ahb_lite_mem_slave
  import ahb_lite_mem_slave_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int LB = $clog2(BW);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [63:0] MEM_BYTES =
    64'(MEM_DEPTH) * 64'(BW);

  state_e r_state;
  state_e w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic r_pend;
  logic r_write;
  logic [2:0] r_size;
  logic [AW-1:0] r_idx;
  logic [LB-1:0] r_lo;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_rword;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [2:0] w_amask;
  logic [BW-1:0] w_be;
  logic w_ready;
  logic w_err;
  logic w_cap;
  logic w_legal;
  logic w_done;
  logic w_unused;

  assign w_unused = ^{HBURST, HPROT,
                      HMASTLOCK, HTRANS[0]};

  assign w_off   = HADDR - BASE_ADDR;
  assign w_ready = (r_state == ST_IDLE) ||
                   (r_state == ST_ERR2);
  assign w_err   = (r_state == ST_ERR1) ||
                   (r_state == ST_ERR2);
  assign w_cap   = w_ready & HSEL & HREADY &
                   HTRANS[1];
  assign w_done  = (r_state == ST_IDLE) & r_pend;

  always_comb begin
    w_amask = 3'd7;
    unique case (HSIZE)
      HS_BYTE: w_amask = 3'd0;
      HS_HALF: w_amask = 3'd1;
      HS_WORD: w_amask = 3'd3;
      default: w_amask = 3'd7;
    endcase
  end

  assign w_legal = (HSIZE <= 3'(LB)) &&
                   ((HADDR[2:0] & w_amask) == 3'd0) &&
                   (64'(w_off) < MEM_BYTES);

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_next = ST_IDLE;
        if (w_cap && !w_legal) begin
          w_next = ST_ERR1;
        end else if (w_cap && WAIT_STATES != 0) begin
          w_next    = ST_WAIT;
          w_cnt_nxt = 4'(WAIT_STATES - 1);
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ERR1: w_next = ST_ERR2;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_idx   <= '0;
      r_lo    <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_rdata <= HRDATA;
      if (w_ready) begin
        r_pend <= w_cap & w_legal;
      end
      if (w_cap) begin
        r_write <= HWRITE;
        r_size  <= HSIZE;
        r_idx   <= w_off[LB +: AW];
        r_lo    <= w_off[LB-1:0];
      end
    end
  end

  assign w_be = BW'(lane_mask(r_size, 3'(r_lo)));

  ahb_lite_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .i_clk   (HCLK),
    .i_we    (w_done & r_write & ~HRESET),
    .i_be    (w_be),
    .i_addr  (r_idx),
    .i_wdata (HWDATA),
    .o_rdata (w_rword)
  );

  assign HREADYOUT = w_ready;
  assign HRESP     = w_err ? RESP_ERROR : RESP_OKAY;

  // Full word on completing read; ERROR forces zero.
  always_comb begin
    HRDATA = r_rdata;
    if (w_err) begin
      HRDATA = '0;
    end else if (w_done && !r_write) begin
      HRDATA = w_rword;
    end
  end

endmodule
